// File: rtl/pid_loop_sequencer_pkg.sv
// Shared types and widths for the velocity-loop sequencer: FSM encoding,
// datapath widths and gain-button bit positions.
package pid_loop_sequencer_pkg;

   localparam int VEL_W  = 16;
   localparam int GAIN_W = 16;
   localparam int DUTY_W = 32;

   localparam int BTN_KP_INC = 0;
   localparam int BTN_KP_DEC = 1;
   localparam int BTN_KI_INC = 2;
   localparam int BTN_KI_DEC = 3;
   localparam int BTN_N      = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SAMPLE = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_UPDATE = 3'd4
   } state_t;

endpackage

// File: rtl/pid_loop_sequencer_if.sv
// Signal bundle between the sequencer (master) and the decoder / PID core /
// PWM side of the velocity loop (slave).
interface pid_loop_sequencer_if;
   import pid_loop_sequencer_pkg::*;

   logic [VEL_W-1:0]         velocity;
   logic                     hold;
   logic                     kp_inc;
   logic                     kp_dec;
   logic                     ki_inc;
   logic                     ki_dec;
   logic                     pid_start;
   logic [VEL_W-1:0]         pv;
   logic [GAIN_W-1:0]        kp;
   logic [GAIN_W-1:0]        ki;
   logic                     pid_valid;
   logic signed [DUTY_W-1:0] pid_un;
   logic [DUTY_W-1:0]        duty;
   logic                     duty_valid;
   logic                     busy;
   logic                     timeout;
   logic                     overrun;

   modport master (
      input  velocity, hold, kp_inc, kp_dec, ki_inc, ki_dec, pid_valid, pid_un,
      output pid_start, pv, kp, ki, duty, duty_valid, busy, timeout, overrun
   );

   modport slave (
      output velocity, hold, kp_inc, kp_dec, ki_inc, ki_dec, pid_valid, pid_un,
      input  pid_start, pv, kp, ki, duty, duty_valid, busy, timeout, overrun
   );

endinterface

// File: rtl/pid_loop_sequencer_rise_edge.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a
// 0->1 transition on an already-debounced level.
module pid_loop_sequencer_rise_edge (
   input  logic clk,
   input  logic n_reset,
   input  logic level,
   output logic rise
);

   logic level_q;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         level_q <= 1'b0;
         rise    <= 1'b0;
      end else begin
         level_q <= level;
         rise    <= level & ~level_q;
      end
   end

endmodule

// File: rtl/pid_loop_sequencer.sv
// One closed-loop velocity iteration per sample tick: snapshot velocity,
// kick the PID core, clamp its result into a PWM duty word, manage gains.
module pid_loop_sequencer
   import pid_loop_sequencer_pkg::*;
#(
   parameter int          SAMPLE_DIV     = 50000,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter int          KP_RESET       = 10,
   parameter int          KI_RESET       = 10,
   parameter int          GAIN_MAX       = 1023,
   parameter logic [31:0] DUTY_MAX       = 32'd65535
) (
   input  logic                 clk,
   input  logic                 n_reset,
   pid_loop_sequencer_if.master bus
);

   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state;
   state_t           state_next;
   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [WW-1:0]    wait_cnt;
   logic             wait_expired;
   logic [BTN_N-1:0] btn;
   logic [BTN_N-1:0] rise;
   logic [BTN_N-1:0] pend;

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [DUTY_W-1:0] v);
      if (v < 0)
         return '0;
      else if (unsigned'(v) > DUTY_MAX)
         return DUTY_MAX;
      else
         return unsigned'(v);
   endfunction

   // Opposing requests cancel; steps saturate at 0 and GAIN_MAX.
   function automatic logic [GAIN_W-1:0] step_gain(input logic [GAIN_W-1:0] g,
                                                   input logic inc, input logic dec);
      if (inc && !dec && (g < GAIN_W'(GAIN_MAX)))
         return g + 1'b1;
      else if (dec && !inc && (g != '0))
         return g - 1'b1;
      else
         return g;
   endfunction

   assign tick         = (tick_cnt == TW'(SAMPLE_DIV - 1));
   assign wait_expired = (wait_cnt == WW'(TIMEOUT_CYCLES - 1));
   assign btn          = {bus.ki_dec, bus.ki_inc, bus.kp_dec, bus.kp_inc};

   for (genvar g = 0; g < BTN_N; g++) begin : g_btn
      pid_loop_sequencer_rise_edge u_edge (
         .clk    (clk),
         .n_reset(n_reset),
         .level  (btn[g]),
         .rise   (rise[g])
      );
   end

   always_comb begin
      state_next    = state;
      bus.pid_start = 1'b0;
      bus.busy      = (state != S_IDLE);
      case (state)
         S_IDLE:   if (tick && !bus.hold) state_next = S_SAMPLE;
         S_SAMPLE: state_next = S_START;
         S_START: begin
            bus.pid_start = 1'b1;
            state_next    = S_WAIT;
         end
         S_WAIT: begin
            if (bus.pid_valid)
               state_next = S_UPDATE;
            else if (wait_expired)
               state_next = S_IDLE;
         end
         S_UPDATE: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state          <= S_IDLE;
         tick_cnt       <= '0;
         wait_cnt       <= '0;
         pend           <= '0;
         bus.pv         <= '0;
         bus.kp         <= GAIN_W'(KP_RESET);
         bus.ki         <= GAIN_W'(KI_RESET);
         bus.duty       <= '0;
         bus.duty_valid <= 1'b0;
         bus.timeout    <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         state          <= state_next;
         tick_cnt       <= tick ? '0 : tick_cnt + 1'b1;
         wait_cnt       <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
         bus.duty_valid <= 1'b0;

         if (state == S_SAMPLE)
            bus.pv <= bus.velocity;

         // Result is clamped at the valid edge so duty lands while in UPDATE.
         if (state == S_WAIT) begin
            if (bus.pid_valid) begin
               bus.duty       <= clamp_duty(bus.pid_un);
               bus.duty_valid <= 1'b1;
            end else if (wait_expired) begin
               bus.duty       <= '0;
               bus.duty_valid <= 1'b1;
               bus.timeout    <= 1'b1;
            end
         end

         if (tick && (state != S_IDLE))
            bus.overrun <= 1'b1;

         if (state == S_IDLE) begin
            bus.kp <= step_gain(bus.kp, pend[BTN_KP_INC], pend[BTN_KP_DEC]);
            bus.ki <= step_gain(bus.ki, pend[BTN_KI_INC], pend[BTN_KI_DEC]);
            pend   <= rise;
         end else begin
            pend   <= pend | rise;
         end
      end
   end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Self-checking bench for pid_loop_sequencer: PID-core model with a duty
// scoreboard, gain-button, hold, timeout, overrun and reset scenarios.
module tb_pid_loop_sequencer;
   import pid_loop_sequencer_pkg::*;

   localparam int SDIV = 16;
   localparam int TMO  = 8;
   localparam int GMAX = 16;

   logic clk = 1'b0;
   logic n_reset = 1'b0;
   always #5 clk = ~clk;

   pid_loop_sequencer_if bus();
   pid_loop_sequencer_if bus2();

   pid_loop_sequencer #(
      .SAMPLE_DIV(SDIV), .TIMEOUT_CYCLES(TMO), .KP_RESET(10), .KI_RESET(10),
      .GAIN_MAX(GMAX), .DUTY_MAX(32'd65535)
   ) dut (
      .clk(clk), .n_reset(n_reset), .bus(bus)
   );

   // Long timeout lets a late PID result straddle the next tick.
   pid_loop_sequencer #(
      .SAMPLE_DIV(SDIV), .TIMEOUT_CYCLES(64)
   ) dut_ovr (
      .clk(clk), .n_reset(n_reset), .bus(bus2)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int starts = 0;
   int starts2 = 0;
   int dv_count = 0;
   int start_cyc = 0;
   int valid_cyc = 0;
   int countdown = 0;
   int model_delay = 3;
   logic model_en = 1'b1;
   logic signed [31:0] model_un = 32'sd500;
   int cur_vel = 120;
   logic [31:0] exp_q[$];

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] clamp_ref(input logic signed [31:0] u);
      if (u[31]) return 32'd0;
      if (u > 32'sd65535) return 32'd65535;
      return u;
   endfunction

   always @(posedge clk or negedge n_reset)
      if (!n_reset) cyc <= 0;
      else cyc <= cyc + 1;

   // PID-core model and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (!n_reset) begin
         countdown     = 0;
         bus.pid_valid = 1'b0;
         bus.pid_un    = '0;
      end else begin
         if (bus.duty_valid) begin
            dv_count++;
            if (exp_q.size() == 0) check_eq("duty_valid_unexpected", exp_q.size(), 1);
            else check_eq("duty", bus.duty, exp_q.pop_front());
         end
         if (bus.pid_valid) bus.pid_valid = 1'b0;
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               bus.pid_valid = 1'b1;
               bus.pid_un    = model_un;
               valid_cyc     = cyc;
            end
         end
         if (bus.pid_start) begin
            starts++;
            start_cyc = cyc;
            check_eq("start_phase", cyc % SDIV, 1);
            check_eq("pv", bus.pv, cur_vel);
            if (model_en) begin
               countdown = model_delay;
               exp_q.push_back(clamp_ref(model_un));
            end else begin
               exp_q.push_back(32'd0);
            end
         end
         if (bus2.pid_start) starts2++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_start(input int budget);
      int n0;
      int k;
      n0 = starts;
      k  = 0;
      while (starts == n0 && k < budget) begin step(); k++; end
      check_eq("wait_start", starts, n0 + 1);
   endtask

   task automatic wait_dv(input int budget);
      int n0;
      int k;
      n0 = dv_count;
      k  = 0;
      while (dv_count == n0 && k < budget) begin step(); k++; end
      check_eq("wait_duty_valid", dv_count, n0 + 1);
   endtask

   task automatic set_btn(input int which, input logic v);
      case (which)
         BTN_KP_INC: bus.kp_inc = v;
         BTN_KP_DEC: bus.kp_dec = v;
         BTN_KI_INC: bus.ki_inc = v;
         default:    bus.ki_dec = v;
      endcase
   endtask

   task automatic press(input int which, input int times);
      for (int i = 0; i < times; i++) begin
         set_btn(which, 1'b1);
         step(); step();
         set_btn(which, 1'b0);
         step(); step();
      end
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_busy"}, bus.busy, 0);
      check_eq({tag, "_pid_start"}, bus.pid_start, 0);
      check_eq({tag, "_pv"}, bus.pv, 0);
      check_eq({tag, "_kp"}, bus.kp, 10);
      check_eq({tag, "_ki"}, bus.ki, 10);
      check_eq({tag, "_duty"}, bus.duty, 0);
      check_eq({tag, "_duty_valid"}, bus.duty_valid, 0);
      check_eq({tag, "_timeout"}, bus.timeout, 0);
      check_eq({tag, "_overrun"}, bus.overrun, 0);
   endtask

   initial begin
      int n0;
      bus.velocity = 16'd120;
      bus.hold = 1'b0;
      bus.kp_inc = 1'b0; bus.kp_dec = 1'b0; bus.ki_inc = 1'b0; bus.ki_dec = 1'b0;
      bus2.velocity = 16'd5;
      bus2.hold = 1'b0;
      bus2.kp_inc = 1'b0; bus2.kp_dec = 1'b0; bus2.ki_inc = 1'b0; bus2.ki_dec = 1'b0;
      bus2.pid_valid = 1'b0;
      bus2.pid_un = '0;
      repeat (3) step();
      check_reset_values("rst");
      n_reset = 1'b1;

      // Basic iteration: start at T+2, duty 500 one cycle after valid.
      wait_start(40);
      check_eq("t1_first_start_cyc", start_cyc, SDIV + 1);
      wait_dv(20);
      check_eq("t1_dv_latency", cyc - valid_cyc, 1);
      check_eq("t1_busy_in_update", bus.busy, 1);
      step();
      check_eq("t1_dv_one_cycle", bus.duty_valid, 0);
      check_eq("t1_idle", bus.busy, 0);

      // Negative result clamps to 0, new velocity snapshot.
      model_un = -32'sd7;
      cur_vel = 77;
      bus.velocity = 16'd77;
      wait_start(40);
      wait_dv(20);

      // Second instance: valid never came before the next tick.
      while (cyc < 42) step();
      check_eq("ovr_overrun", bus2.overrun, 1);
      check_eq("ovr_single_start", starts2, 1);
      check_eq("ovr_busy", bus2.busy, 1);
      check_eq("main_no_overrun", bus.overrun, 0);

      // Large positive result clamps to DUTY_MAX.
      model_un = 32'sd100000;
      wait_start(40);
      wait_dv(20);

      // Kp button pressed during WAIT applies only after return to IDLE.
      model_un = 32'sd500;
      wait_start(40);
      step();
      bus.kp_inc = 1'b1;
      wait_dv(20);
      check_eq("t4_kp_frozen", bus.kp, 10);
      bus.kp_inc = 1'b0;
      bus.hold = 1'b1;
      step(); step(); step();
      check_eq("t4_kp_applied", bus.kp, 11);

      press(BTN_KI_DEC, 12);
      step(); step();
      check_eq("t4_ki_floor", bus.ki, 0);
      press(BTN_KI_INC, 1);
      step(); step();
      check_eq("t4_ki_inc", bus.ki, 1);
      press(BTN_KP_INC, 8);
      step(); step();
      check_eq("t4_kp_ceiling", bus.kp, GMAX);
      bus.kp_inc = 1'b1;
      bus.kp_dec = 1'b1;
      step(); step();
      bus.kp_inc = 1'b0;
      bus.kp_dec = 1'b0;
      repeat (3) step();
      check_eq("t4_kp_inc_dec_cancel", bus.kp, GMAX);

      // Hold: no new iterations, duty frozen, no overrun.
      n0 = starts;
      repeat (40) step();
      check_eq("hold_no_start", starts, n0);
      check_eq("hold_duty_frozen", bus.duty, 500);
      check_eq("hold_no_overrun", bus.overrun, 0);
      bus.hold = 1'b0;

      // Timeout: 8 WAIT cycles, duty forced to 0, next tick restarts.
      model_en = 1'b0;
      wait_start(40);
      check_eq("t3_timeout_before", bus.timeout, 0);
      wait_dv(30);
      check_eq("t3_timeout_latency", cyc - start_cyc, TMO + 1);
      check_eq("t3_timeout_flag", bus.timeout, 1);
      check_eq("t3_idle_after", bus.busy, 0);
      model_en = 1'b1;
      model_un = 32'sd300;
      wait_start(40);
      wait_dv(20);
      check_eq("t3_timeout_sticky", bus.timeout, 1);

      // Reset in WAIT: immediate reset values, no duty_valid.
      model_en = 1'b0;
      wait_start(40);
      step(); step();
      check_eq("t6_in_wait", bus.busy, 1);
      n_reset = 1'b0;
      #1;
      check_reset_values("t6_rst");
      exp_q.delete();
      n0 = dv_count;
      repeat (3) step();
      check_eq("t6_no_dv", dv_count, n0);
      model_en = 1'b1;
      model_un = 32'sd500;
      n_reset = 1'b1;
      wait_start(40);
      check_eq("t6_restart_cyc", start_cyc, SDIV + 1);
      wait_dv(20);
      check_eq("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
